seq_shift_add_multiplier: RTL and testbench

//   Parametrised unsigned WIDTH x WIDTH multiplier, radix-2 shift-and-add, one multiplier bit per clock.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_add_shift_dp.sv | 55 +++++
 rtl/seq_shift_add_multiplier.sv | 100 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  // Bit count needed to index WIDTH multiplier bits (0..WIDTH-1).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mult_add_shift_dp.sv
// Shift-and-add datapath: accumulator, left-shifting multiplicand, right-shifting multiplier.
// With MULT_EARLY_TERM_EN defined, mplier_empty_c flags that no multiplier bits remain.
module mult_add_shift_dp
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next_c,
  output logic               mplier_empty_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;

  // Operand capture on load, one multiplier bit consumed per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= PW'(a);
      mplier <= b;
    end else if (step) begin
      acc    <= acc_next_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Accumulator value after the current multiplier bit; 2*WIDTH bits cannot overflow.
  always_comb begin
    acc_next_c = acc;
    if (mplier[0]) begin
      acc_next_c = acc + mcand;
    end
  end

`ifdef MULT_EARLY_TERM_EN
  assign mplier_empty_c = (mplier == '0);
`else
  assign mplier_empty_c = 1'b0;
`endif

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH sequential multiplier, one multiplier bit per clock, start/busy/done handshake.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic          finish;
  logic [PW-1:0] acc_next_c;
  logic          mplier_empty_c;

  // A request is only honoured when not running (IDLE or DONE).
  assign load   = start && (state != RUN);
  assign step   = (state == RUN);
  assign finish = step && (mplier_empty_c || (cnt == LAST));

  mult_add_shift_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .step          (step),
    .a             (a),
    .b             (b),
    .acc_next_c    (acc_next_c),
    .mplier_empty_c(mplier_empty_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the registered state directly.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Bit counter; restarts on every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Result register changes only on the edge entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
    end else if (finish) begin
      product <= acc_next_c;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: directed cases at WIDTH=8 plus random streams at WIDTH=4, 8 and 16,
// all checked every cycle against a transaction-level model (countdown + a*b).
module tb_seq_shift_add_multiplier;

  localparam int NDUT  = 4;
  localparam int NRAND = 1000;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   nfin     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles from the accepting edge until done is visible.
  function automatic int exp_lat(input int w, input logic [63:0] bv);
    int msb;
    int r;
    msb = -1;
    for (int i = 0; i < 64; i++) if (bv[i]) msb = i;
    r = w;
    if (EARLY) begin
      r = (msb < 0) ? 1 : msb + 2;
      if (r > w) r = w;
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int unsigned W = (gi == 1) ? 4 : (gi == 3) ? 16 : 8;

    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    seq_shift_add_multiplier #(
      .WIDTH(W)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .product(product)
    );

    int               left   = 0;
    logic             m_done = 1'b0;
    logic [63:0]      m_prod = '0;
    logic [63:0]      pend   = '0;

    // Model update from inputs seen at the edge, then compare just after it.
    always begin : cmp
      logic        s_rst;
      logic        s_start;
      logic [63:0] s_a;
      logic [63:0] s_b;
      @(posedge clk);
      s_rst   = rst;
      s_start = start;
      s_a     = 64'(a);
      s_b     = 64'(b);
      #1;
      if (s_rst || rst) begin
        left   = 0;
        m_done = 1'b0;
        m_prod = '0;
      end else begin
        if (left > 0) begin
          left--;
          m_done = (left == 0);
          if (m_done) m_prod = pend;
        end else begin
          m_done = 1'b0;
          if (s_start) begin
            left = exp_lat(W, s_b);
            pend = s_a * s_b;
          end
        end
        chk($sformatf("w%0d.%0d busy", W, gi), 64'(busy), 64'(left > 0));
        chk($sformatf("w%0d.%0d done", W, gi), 64'(done), 64'(m_done));
        chk($sformatf("w%0d.%0d product", W, gi), 64'(product), m_prod);
      end
    end

    if (gi == 0) begin : g_dir
      // Present a request on this negedge, withdraw it on the next.
      task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
      endtask

      task automatic wait_done(input string name, input int limit, output int k);
        k = 0;
        while (!done && k < limit) begin
          @(negedge clk);
          k++;
        end
        chk({name, " done seen"}, 64'(done), 64'h1);
      endtask

      initial begin
        int k;
        int dn;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset done", 64'(done), 64'h0);
        chk("reset product", 64'(product), 64'h0);

        launch(8'hFF, 8'hFF);
        chk("ff busy", 64'(busy), 64'h1);
        wait_done("ff", 40, k);
        chk("ff latency", 64'(k), 64'd8);
        chk("ff product", 64'(product), 64'hFE01);
        @(negedge clk);
        chk("ff done one cycle", 64'(done), 64'h0);

        launch(8'd13, 8'd11);
        wait_done("13x11", 40, k);
        chk("13x11 product", 64'(product), 64'd143);
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd5;
        @(negedge clk);
        start = 1'b0;
        a     = 8'hEE;
        b     = 8'hEE;
        chk("b2b accepted", 64'(busy), 64'h1);
        wait_done("3x5", 40, k);
        chk("b2b spacing", 64'(k + 1), 64'(exp_lat(8, 64'd5) + 1));
        chk("3x5 product", 64'(product), 64'd15);

        launch(8'h00, 8'hA5);
        wait_done("0xa5", 40, k);
        chk("0xa5 latency", 64'(k), 64'(exp_lat(8, 64'hA5)));
        chk("0xa5 product", 64'(product), 64'h0);
        launch(8'hA5, 8'h01);
        wait_done("a5x1", 40, k);
        chk("a5x1 latency", 64'(k), 64'(exp_lat(8, 64'h01)));
        chk("a5x1 product", 64'(product), 64'h00A5);

        launch(8'h77, 8'h00);
        wait_done("77x0", 40, k);
        chk("77x0 latency", 64'(k), 64'(exp_lat(8, 64'h00)));
        chk("77x0 product", 64'(product), 64'h0);
        launch(8'h10, 8'h04);
        wait_done("10x04", 40, k);
        chk("10x04 latency", 64'(k), 64'(exp_lat(8, 64'h04)));
        chk("10x04 product", 64'(product), 64'h0040);

        launch(8'd2, 8'd2);
        launch(8'd7, 8'd7);
        wait_done("ignore", 40, k);
        chk("ignore product", 64'(product), 64'd4);
        dn = 0;
        repeat (12) begin
          @(negedge clk);
          if (done) dn++;
        end
        chk("ignore single done", 64'(dn), 64'h0);

        launch(8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 64'(busy), 64'h0);
        chk("async rst done", 64'(done), 64'h0);
        chk("async rst product", 64'(product), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        repeat (12) begin
          @(negedge clk);
          if (done) dn++;
        end
        chk("no done after abort", 64'(dn), 64'h0);
        chk("product after abort", 64'(product), 64'h0);
        nfin++;
      end
    end else begin : g_rnd
      function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
          0:       return '0;
          1:       return '1;
          default: return W'($urandom);
        endcase
      endfunction

      initial begin
        int got;
        int cyc;
        got   = 0;
        cyc   = 0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        while (rst !== 1'b0) @(negedge clk);
        while (got < NRAND && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (done) got++;
          start = ($urandom_range(0, 3) != 0);
          a     = pick();
          b     = pick();
        end
        start = 1'b0;
        chk($sformatf("w%0d completions", W), 64'(got), 64'(NRAND));
        nfin++;
      end
    end
  end

  initial begin
    int c;
    c = 0;
    @(negedge clk);
    while (nfin < NDUT && c < 80000) begin
      @(negedge clk);
      c++;
    end
    chk("all streams finished", 64'(nfin), 64'(NDUT));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
